// File: rtl/axis_pkt_guard_pkg.sv
// Shared types and helpers for the AXI-Stream packet guard.
package axis_pkt_guard_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        SEND = 2'd2
    } state_t;

    // Increment that sticks at 2^width-1; width is limited to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/axis_pkt_guard_cnt.sv
// Saturating event counter with enable, used for the drop and forward counts.
module axis_pkt_guard_cnt
    import axis_pkt_guard_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= W'(sat_inc(32'(r_cnt), W));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/axis_pkt_guard.sv
// Buffers one fixed-length AXI-Stream packet and forwards it only if well-formed.
// Define AXIS_PKT_GUARD_TKEEP_CHECK_EN to also drop packets carrying partial tkeep.
//
// state | meaning
// FILL  | accepting beats into the buffer
// DROP  | over-length packet, discarding beats until tlast
// SEND  | replaying the buffered packet downstream
module axis_pkt_guard
    import axis_pkt_guard_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 128,
    parameter int PKT_WORDS_NUM = 10,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_areset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      drop_pulse,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic [CNT_WIDTH-1:0]      fwd_cnt
);

    localparam int KEEP_W = C_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(PKT_WORDS_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS_NUM - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [C_DATA_WIDTH-1:0]   r_buf [PKT_WORDS_NUM];
    logic                      r_drop_pulse;

    logic w_s_hs;
    logic w_m_hs;
    logic w_drop_evt;
    logic w_fwd_evt;
    logic w_to_send;
    logic w_bad_now;

    assign s_axis_tready = (r_state != SEND);
    assign m_axis_tvalid = (r_state == SEND);
    assign m_axis_tdata  = r_buf[r_idx];
    assign m_axis_tlast  = (r_state == SEND) && (r_idx == LAST_IDX);
    assign m_axis_tkeep  = {KEEP_W{1'b1}};
    assign drop_pulse    = r_drop_pulse;

    assign w_s_hs = s_axis_tvalid && s_axis_tready;
    assign w_m_hs = m_axis_tvalid && m_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_drop_evt  = 1'b0;
        w_fwd_evt   = 1'b0;
        w_to_send   = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_s_hs) begin
                    if (s_axis_tlast) begin
                        w_idx_nxt = '0;
                        if (r_idx == LAST_IDX && !w_bad_now) begin
                            w_state_nxt = SEND;
                            w_to_send   = 1'b1;
                        end else begin
                            w_drop_evt  = 1'b1;
                        end
                    end else if (r_idx == LAST_IDX) begin
                        w_state_nxt = DROP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            DROP: begin
                if (w_s_hs && s_axis_tlast) begin
                    w_drop_evt  = 1'b1;
                    w_state_nxt = FILL;
                    w_idx_nxt   = '0;
                end
            end
            SEND: begin
                if (w_m_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_fwd_evt   = 1'b1;
                        w_state_nxt = FILL;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_drop_pulse <= w_drop_evt;
        end
    end

    // Data storage is deliberately left out of reset.
    always_ff @(posedge s_axis_aclk) begin
        if (r_state == FILL && w_s_hs) begin
            r_buf[r_idx] <= s_axis_tdata;
        end
    end

`ifdef AXIS_PKT_GUARD_TKEEP_CHECK_EN
    logic r_bad;
    logic w_keep_bad;

    assign w_keep_bad = (s_axis_tkeep != {KEEP_W{1'b1}});
    // Include the current beat so a partial tkeep on the closing beat still drops.
    assign w_bad_now  = r_bad || (w_s_hs && w_keep_bad);

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_bad <= 1'b0;
        end else if (w_drop_evt || w_to_send) begin
            r_bad <= 1'b0;
        end else if (w_s_hs && w_keep_bad) begin
            r_bad <= 1'b1;
        end
    end
`else
    logic w_unused_tkeep;

    assign w_bad_now      = 1'b0;
    assign w_unused_tkeep = ^s_axis_tkeep;
`endif

    axis_pkt_guard_cnt #(.W(CNT_WIDTH)) u_drop_cnt (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .i_en  (w_drop_evt),
        .o_cnt (drop_cnt)
    );

    axis_pkt_guard_cnt #(.W(CNT_WIDTH)) u_fwd_cnt (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .i_en  (w_fwd_evt),
        .o_cnt (fwd_cnt)
    );

endmodule

// File: tb/tb_axis_pkt_guard.sv
// Directed bench for axis_pkt_guard; a second instance with 2-bit counters covers saturation.
module tb_axis_pkt_guard;

    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int N  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata  = '0;
    logic [KW-1:0] s_tkeep  = '1;
    logic          s_tlast  = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          drop_pulse;
    logic [15:0]   drop_cnt;
    logic [15:0]   fwd_cnt;

    logic          sat_s_tready;
    logic          sat_m_tvalid;
    logic [DW-1:0] sat_m_tdata;
    logic [KW-1:0] sat_m_tkeep;
    logic          sat_m_tlast;
    logic          sat_drop_pulse;
    logic [1:0]    sat_drop_cnt;
    logic [1:0]    sat_fwd_cnt;

    axis_pkt_guard #(.C_DATA_WIDTH(DW), .PKT_WORDS_NUM(N), .CNT_WIDTH(16)) dut (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .fwd_cnt(fwd_cnt)
    );

    axis_pkt_guard #(.C_DATA_WIDTH(DW), .PKT_WORDS_NUM(N), .CNT_WIDTH(2)) dut_sat (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(sat_s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(sat_m_tdata),
        .m_axis_tkeep(sat_m_tkeep), .m_axis_tlast(sat_m_tlast),
        .drop_pulse(sat_drop_pulse), .drop_cnt(sat_drop_cnt), .fwd_cnt(sat_fwd_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: everything sampled on the falling edge, i.e. the values the next rising edge acts on.
    int            cyc = 0;
    logic [DW-1:0] rx_data [$];
    logic          rx_last [$];
    int            pulse_cnt = 0, sat_pulse_cnt = 0;
    int            stall_err = 0, sready_err = 0, notready_cnt = 0, stall_cycles = 0;
    int            last_s_cyc = 0, first_m_cyc = 0;
    logic          prev_mvalid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, exp_ready_next = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
                stall_err++;
            if (exp_ready_next && s_tready !== 1'b1) sready_err++;
            if (m_tvalid && s_tready) sready_err++;
            if (s_tvalid && !s_tready) notready_cnt++;
            if (s_tvalid && s_tready && s_tlast) last_s_cyc = cyc;
            if (m_tvalid && !prev_mvalid) first_m_cyc = cyc;
            if (drop_pulse) pulse_cnt++;
            if (sat_drop_pulse) sat_pulse_cnt++;
            if (m_tvalid && !m_tready) stall_cycles++;
            if (m_tvalid && m_tready) begin
                rx_data.push_back(m_tdata);
                rx_last.push_back(m_tlast);
            end
            exp_ready_next = m_tvalid && m_tready && m_tlast;
            prev_stall     = m_tvalid && !m_tready;
            prev_data      = m_tdata;
            prev_last      = m_tlast;
            prev_mvalid    = m_tvalid;
        end else begin
            prev_stall     = 1'b0;
            prev_mvalid    = 1'b0;
            exp_ready_next = 1'b0;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [KW-1:0] k);
        int   w;
        logic ok;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tkeep  = k;
        w = 0;
        forever begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            if (ok) break;
            w++;
            if (w > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
    endtask

    // n beats from base upward, tlast on the final beat; bad_beat (1-based) carries tkeep 0x00FF.
    task automatic send_pkt(input int n, input logic [DW-1:0] base, input int bad_beat);
        for (int i = 0; i < n; i++)
            send_beat(base + DW'(i), (i == n - 1), (i + 1 == bad_beat) ? KW'(16'h00FF) : {KW{1'b1}});
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (s_tready && !m_tvalid) break;
            w++;
            if (w > 200) begin
                chk("idle_timeout", 1, 0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string tag, input logic [DW-1:0] base);
        chk($sformatf("%s_beats", tag), DW'(rx_data.size()), DW'(N));
        for (int i = 0; i < N && i < rx_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), rx_data[i], base + DW'(i));
            chk($sformatf("%s_last%0d", tag, i), DW'(rx_last[i]), DW'(i == N - 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int p0, nr0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_tready", DW'(s_tready), 1);
        chk("rst_m_tvalid", DW'(m_tvalid), 0);
        chk("rst_m_tlast", DW'(m_tlast), 0);
        chk("rst_drop_pulse", DW'(drop_pulse), 0);
        chk("rst_drop_cnt", DW'(drop_cnt), 0);
        chk("rst_fwd_cnt", DW'(fwd_cnt), 0);
        chk("rst_m_tkeep", DW'(m_tkeep), DW'({KW{1'b1}}));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Saturation: five early-tlast packets including the single-beat case
        send_pkt(1, 'h10, 0);
        send_pkt(2, 'h20, 0);
        send_pkt(3, 'h30, 0);
        send_pkt(4, 'h40, 0);
        send_pkt(9, 'h50, 0);
        wait_idle();
        chk("sat_drop_cnt16", DW'(drop_cnt), 5);
        chk("sat_drop_cnt2", DW'(sat_drop_cnt), 3);
        chk("sat_pulses16", DW'(pulse_cnt), 5);
        chk("sat_pulses2", DW'(sat_pulse_cnt), 5);
        chk("sat_fwd_cnt", DW'(fwd_cnt), 0);
        chk("sat_rx_beats", DW'(rx_data.size()), 0);
        do_reset();
        chk("sat_clear_drop", DW'(drop_cnt), 0);

        // Good packet
        rx_data.delete();
        rx_last.delete();
        send_pkt(N, 1, 0);
        wait_idle();
        check_rx("good", 1);
        chk("good_latency", DW'(first_m_cyc - last_s_cyc), 1);
        chk("good_fwd_cnt", DW'(fwd_cnt), 1);
        chk("good_drop_cnt", DW'(drop_cnt), 0);

        // Early tlast followed by a good packet
        rx_data.delete();
        rx_last.delete();
        p0 = pulse_cnt;
        send_pkt(4, 'h60, 0);
        send_pkt(N, 'hA0, 0);
        wait_idle();
        check_rx("early", 'hA0);
        chk("early_pulses", DW'(pulse_cnt - p0), 1);
        chk("early_drop_cnt", DW'(drop_cnt), 1);
        chk("early_fwd_cnt", DW'(fwd_cnt), 2);

        // Missing tlast: 13 beats
        rx_data.delete();
        rx_last.delete();
        p0  = pulse_cnt;
        nr0 = notready_cnt;
        send_pkt(13, 'h70, 0);
        wait_idle();
        chk("miss_rx_beats", DW'(rx_data.size()), 0);
        chk("miss_notready", DW'(notready_cnt - nr0), 0);
        chk("miss_pulses", DW'(pulse_cnt - p0), 1);
        chk("miss_drop_cnt", DW'(drop_cnt), 2);
        chk("miss_fwd_cnt", DW'(fwd_cnt), 2);

        // Backpressure: m_tready pattern 1,0,0,1
        rx_data.delete();
        rx_last.delete();
        stall_cycles = 0;
        fork
            send_pkt(N, 'h80, 0);
            begin
                logic [3:0] pat;
                pat = 4'b1001;
                for (int k = 0; k < 60; k++) begin
                    m_tready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                m_tready = 1'b1;
            end
        join
        wait_idle();
        check_rx("bp", 'h80);
        chk("bp_stalled", DW'(stall_cycles > 0), 1);
        chk("bp_stable", DW'(stall_err), 0);
        chk("bp_s_tready", DW'(sready_err), 0);
        chk("bp_fwd_cnt", DW'(fwd_cnt), 3);

        // Reset during SEND after three m beats
        rx_data.delete();
        rx_last.delete();
        m_tready = 1'b1;
        send_pkt(N, 'h30, 0);
        for (int w = 0; w < 50 && rx_data.size() < 3; w++) @(negedge clk);
        chk("rs_pre_beats", DW'(rx_data.size()), 3);
        @(posedge clk);
        #1;
        chk("rs_pre_valid", DW'(m_tvalid), 1);
        rst = 1'b1;
        #1;
        chk("rs_m_tvalid", DW'(m_tvalid), 0);
        chk("rs_s_tready", DW'(s_tready), 1);
        chk("rs_fwd_cnt", DW'(fwd_cnt), 0);
        chk("rs_drop_cnt", DW'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_data.delete();
        rx_last.delete();
        send_pkt(N, 'h90, 0);
        wait_idle();
        check_rx("rs_next", 'h90);
        chk("rs_next_fwd_cnt", DW'(fwd_cnt), 1);

`ifdef AXIS_PKT_GUARD_TKEEP_CHECK_EN
        // Partial tkeep on beat 5 of a correctly sized packet
        rx_data.delete();
        rx_last.delete();
        p0 = pulse_cnt;
        send_pkt(N, 'hC0, 5);
        wait_idle();
        chk("keep_rx_beats", DW'(rx_data.size()), 0);
        chk("keep_drop_cnt", DW'(drop_cnt), 1);
        chk("keep_pulses", DW'(pulse_cnt - p0), 1);
        chk("keep_fwd_cnt", DW'(fwd_cnt), 1);
        rx_data.delete();
        rx_last.delete();
        send_pkt(N, 'hD0, 0);
        wait_idle();
        check_rx("keep_next", 'hD0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
